// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path: game-state encodings and
// default colour constants.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME  = 2'b00,
    ST_PLAY     = 2'b01,
    ST_NEWBALL  = 2'b10,
    ST_GAMEOVER = 2'b11
  } state_e;

  localparam int         RGB_W  = 3;
  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BG_RGB = 3'b110;

endpackage

// File: rtl/pong_game_ctrl_bcd.sv
// Multi-digit BCD counter with synchronous clear and an increment that
// saturates at all nines instead of wrapping.
module bcd_sat_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic                sat_s;
  logic                carry_s;

  // Next count: clear wins, then ripple-carry increment unless saturated.
  always_comb begin
    bcd_d   = bcd_q;
    carry_s = 1'b0;
    sat_s   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd9) begin
        sat_s = 1'b0;
      end else begin
        sat_s = sat_s;
      end
    end
    if (clear) begin
      bcd_d = {(4*DIGITS){1'b0}};
    end else if (inc && !sat_s) begin
      carry_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry_s) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry_s         = 1'b0;
          end
        end else begin
          bcd_d[4*i +: 4] = bcd_q[4*i +: 4];
        end
      end
    end else begin
      bcd_d = bcd_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= {(4*DIGITS){1'b0}};
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller (new game / play / new ball / game over) with
// lives, BCD score, game-over hold timer and the registered pixel compositor.
module pong_game_ctrl #(
  parameter int                             LIVES           = 3,
  parameter int                             SCORE_DIGITS    = 2,
  parameter int                             GAMEOVER_FRAMES = 60,
  parameter int                             RGB_W           = pong_pkg::RGB_W,
  parameter int                             TEXT_LAYERS     = 4,
  parameter logic [RGB_W-1:0]               BG_RGB          = RGB_W'(pong_pkg::BG_RGB)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pixel_tick,
  input  logic                      frame_tick,
  input  logic [1:0]                button,
  input  logic                      hit,
  input  logic                      miss,
  input  logic                      video_on,
  input  logic [TEXT_LAYERS-1:0]    text_on,
  input  logic [RGB_W-1:0]          text_rgb,
  input  logic                      graph_on,
  input  logic [RGB_W-1:0]          graph_rgb,
  output logic                      still_graph,
  output logic [1:0]                state,
  output logic [3:0]                lives,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [RGB_W-1:0]          rgb
);

  import pong_pkg::*;

  localparam int GO_W = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;
  localparam logic [GO_W-1:0] GO_LAST = GO_W'(GAMEOVER_FRAMES - 1);
  localparam logic [3:0]      LIVES_INIT = 4'(LIVES);

  state_e           state_q, state_d;
  logic [3:0]       lives_q, lives_d;
  logic [GO_W-1:0]  go_cnt_q, go_cnt_d;
  logic             btn_q, btn_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [RGB_W-1:0] pix_s;
  logic             press_s;
  logic             score_clr_s;
  logic             score_inc_s;

  assign btn_d       = |button;
  assign press_s     = btn_d & ~btn_q;
  assign score_clr_s = (state_q == ST_NEWGAME);
  // A simultaneous miss suppresses the point for the hit.
  assign score_inc_s = (state_q == ST_PLAY) & hit & ~miss;

  // Game-flow next state, lives and game-over frame counter.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    go_cnt_d = {GO_W{1'b0}};
    case (state_q)
      ST_NEWGAME: begin
        lives_d = LIVES_INIT;
        if (press_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_NEWGAME;
        end
      end
      ST_PLAY: begin
        if (miss) begin
          lives_d = lives_q - 4'd1;
          if (lives_q == 4'd1) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_NEWBALL;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_NEWBALL: begin
        if (press_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_NEWBALL;
        end
      end
      ST_GAMEOVER: begin
        if (frame_tick) begin
          if (go_cnt_q == GO_LAST) begin
            state_d  = ST_NEWGAME;
            go_cnt_d = {GO_W{1'b0}};
          end else begin
            go_cnt_d = go_cnt_q + {{(GO_W-1){1'b0}}, 1'b1};
          end
        end else begin
          go_cnt_d = go_cnt_q;
        end
      end
      default: begin
        state_d = ST_NEWGAME;
      end
    endcase
  end

  // Pixel priority mux, loaded only on pixel-rate enables.
  always_comb begin
    pix_s = BG_RGB;
    if (!video_on) begin
      pix_s = RGB_W'(BLACK);
    end else if (|text_on) begin
      pix_s = text_rgb;
    end else if (graph_on) begin
      pix_s = graph_rgb;
    end else begin
      pix_s = BG_RGB;
    end
    if (pixel_tick) begin
      rgb_d = pix_s;
    end else begin
      rgb_d = rgb_q;
    end
  end

  // State, counters, button history and pixel register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_NEWGAME;
      lives_q  <= LIVES_INIT;
      go_cnt_q <= {GO_W{1'b0}};
      btn_q    <= 1'b0;
      rgb_q    <= {RGB_W{1'b0}};
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      go_cnt_q <= go_cnt_d;
      btn_q    <= btn_d;
      rgb_q    <= rgb_d;
    end
  end

  bcd_sat_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clr_s),
    .inc   (score_inc_s),
    .bcd   (score)
  );

  assign still_graph = (state_q != ST_PLAY);
  assign state       = state_q;
  assign lives       = lives_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: game flow, score saturation, game-over
// hold timing and pixel mux, each against hand-computed values.
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic       pixel_tick;
  logic       frame_tick;
  logic [1:0] button;
  logic       hit;
  logic       miss;
  logic       video_on;
  logic [3:0] text_on;
  logic [2:0] text_rgb;
  logic       graph_on;
  logic [2:0] graph_rgb;
  logic       still_graph;
  logic [1:0] state;
  logic [3:0] lives;
  logic [7:0] score;
  logic [2:0] rgb;

  int tests_run;
  int tests_failed;

  pong_game_ctrl #(
    .LIVES           (3),
    .SCORE_DIGITS    (2),
    .GAMEOVER_FRAMES (60),
    .RGB_W           (3),
    .TEXT_LAYERS     (4),
    .BG_RGB          (3'b110)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_tick  (pixel_tick),
    .frame_tick  (frame_tick),
    .button      (button),
    .hit         (hit),
    .miss        (miss),
    .video_on    (video_on),
    .text_on     (text_on),
    .text_rgb    (text_rgb),
    .graph_on    (graph_on),
    .graph_rgb   (graph_rgb),
    .still_graph (still_graph),
    .state       (state),
    .lives       (lives),
    .score       (score),
    .rgb         (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    tick();
    miss = 1'b0;
  endtask

  task automatic press_btn(input logic [1:0] b);
    button = 2'b00;
    tick();
    button = b;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1; pixel_tick = 1'b0; frame_tick = 1'b0; button = 2'b00;
    hit = 1'b0; miss = 1'b0; video_on = 1'b0; text_on = 4'b0000;
    text_rgb = 3'b011; graph_on = 1'b0; graph_rgb = 3'b101;
    tick(); tick();
    check_val("rst_state", 32'(state), 32'h0);
    check_val("rst_lives", 32'(lives), 32'd3);
    check_val("rst_score", 32'(score), 32'h0);
    check_val("rst_rgb",   32'(rgb),   32'h0);
    check_val("rst_still", 32'(still_graph), 32'd1);
    reset = 1'b0;
    tick();

    // Start game: button held from here on.
    button = 2'b01;
    tick();
    check_val("start_state", 32'(state), 32'h1);
    check_val("start_lives", 32'(lives), 32'd3);
    check_val("start_still", 32'(still_graph), 32'd0);

    pulse_hit(7);
    check_val("score_07", 32'(score), 32'h07);

    // Hit and miss together: miss wins, score unchanged.
    hit = 1'b1;
    pulse_miss();
    hit = 1'b0;
    tick();
    check_val("hm_score", 32'(score), 32'h07);
    check_val("hm_lives", 32'(lives), 32'd2);
    check_val("hm_state", 32'(state), 32'h2);
    check_val("nb_still", 32'(still_graph), 32'd1);

    // Held button must not restart; hit/miss ignored in NEWBALL.
    tick(); tick();
    check_val("held_state", 32'(state), 32'h2);
    pulse_hit(1);
    pulse_miss();
    tick();
    check_val("nb_score", 32'(score), 32'h07);
    check_val("nb_lives", 32'(lives), 32'd2);
    check_val("nb_state2", 32'(state), 32'h2);

    press_btn(2'b10);
    check_val("repress_state", 32'(state), 32'h1);
    pulse_hit(3);
    check_val("score_10", 32'(score), 32'h10);
    pulse_hit(95);
    check_val("score_sat", 32'(score), 32'h99);
    pulse_hit(2);
    check_val("score_sat2", 32'(score), 32'h99);

    pulse_miss();
    tick();
    check_val("m2_lives", 32'(lives), 32'd1);
    check_val("m2_state", 32'(state), 32'h2);

    press_btn(2'b01);
    check_val("play3_state", 32'(state), 32'h1);
    pulse_miss();
    tick();
    check_val("go_state", 32'(state), 32'h3);
    check_val("go_lives", 32'(lives), 32'd0);
    check_val("go_score", 32'(score), 32'h99);
    check_val("go_still", 32'(still_graph), 32'd1);

    // Press during GAMEOVER has no effect.
    press_btn(2'b11);
    check_val("go_press", 32'(state), 32'h3);
    button = 2'b00;

    for (int f = 0; f < 59; f++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
    check_val("go59_state", 32'(state), 32'h3);
    check_val("go59_score", 32'(score), 32'h99);
    check_val("go59_lives", 32'(lives), 32'd0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_val("go60_state", 32'(state), 32'h0);
    tick();
    check_val("ng_score", 32'(score), 32'h00);
    check_val("ng_lives", 32'(lives), 32'd3);

    // Pixel mux priority, one-tick latency.
    pixel_tick = 1'b1; video_on = 1'b0; text_on = 4'b0100; graph_on = 1'b1;
    tick();
    check_val("pix_blank", 32'(rgb), 32'h0);
    video_on = 1'b1;
    tick();
    check_val("pix_text", 32'(rgb), 32'h3);
    text_on = 4'b0000;
    tick();
    check_val("pix_graph", 32'(rgb), 32'h5);
    graph_on = 1'b0;
    tick();
    check_val("pix_bg", 32'(rgb), 32'h6);
    pixel_tick = 1'b0; graph_on = 1'b1;
    tick(); tick();
    check_val("pix_hold", 32'(rgb), 32'h6);

    // Async reset in the middle of play.
    press_btn(2'b01);
    check_val("pre_rst_state", 32'(state), 32'h1);
    pulse_hit(2);
    reset = 1'b1;
    #2;
    check_val("arst_state", 32'(state), 32'h0);
    check_val("arst_rgb",   32'(rgb),   32'h0);
    check_val("arst_score", 32'(score), 32'h0);
    check_val("arst_still", 32'(still_graph), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
